// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, flag struct and flag bit positions shared by the ALU pipeline and its bench.
package alu_pipe_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR,
        OP_SAR, OP_ROL, OP_ROR, OP_INC, OP_DEC, OP_SLT, OP_MUL, OP_PASS
    } alu_op_e;

    typedef struct packed {
        logic illegal;
        logic ovf;
        logic neg;
        logic zero;
        logic carry;
    } alu_flags_t;

    localparam int FLAG_CARRY   = 0;
    localparam int FLAG_ZERO    = 1;
    localparam int FLAG_NEG     = 2;
    localparam int FLAG_OVF     = 3;
    localparam int FLAG_ILLEGAL = 4;
endpackage

// File: rtl/alu_pipe_exec.sv
// alu_pipe_exec: combinational ALU datapath; define ALU_PIPE_MUL_EN to build the multiplier for OP_MUL.
module alu_pipe_exec import alu_pipe_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          sel,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0] sh;
    logic [WIDTH:0] add_w, sub_w, shl_w, shr_w, sar_w;
`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] prod;
`endif
    always_comb begin
        sh = b[SHW-1:0];
        add_w = {1'b0, a} + {1'b0, b};
        sub_w = {1'b0, a} - {1'b0, b};
        shl_w = {1'b0, a} << sh;
        shr_w = {a, 1'b0} >> sh;
        sar_w = $signed({a, 1'b0}) >>> sh;
`ifdef ALU_PIPE_MUL_EN
        prod = a * b;
`endif
        result = '0;
        flags = '0;
        case (sel)
            OP_ADD: begin
                {flags.carry, result} = add_w;
                flags.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                {flags.carry, result} = sub_w;
                flags.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  {flags.carry, result} = shl_w;
            OP_SHR:  {result, flags.carry} = shr_w;
            OP_SAR:  {result, flags.carry} = sar_w;
            OP_ROL:  result = (a << sh) | (a >> (WIDTH - int'(sh)));
            OP_ROR:  result = (a >> sh) | (a << (WIDTH - int'(sh)));
            OP_INC: begin
                {flags.carry, result} = {1'b0, a} + (WIDTH+1)'(1);
                flags.ovf = !a[WIDTH-1] && result[WIDTH-1];
            end
            OP_DEC: begin
                {flags.carry, result} = {1'b0, a} - (WIDTH+1)'(1);
                flags.ovf = a[WIDTH-1] && !result[WIDTH-1];
            end
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin
                result = prod[WIDTH-1:0];
                flags.carry = |prod[2*WIDTH-1:WIDTH];
            end
`else
            OP_MUL:  flags.illegal = 1'b1;
`endif
            OP_PASS: result = b;
        endcase
        flags.zero = result == '0;
        flags.neg = result[WIDTH-1];
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline (operand stage, result stage); ALU_PIPE_MUL_EN enables OP_MUL.
module alu_pipe import alu_pipe_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [4:0]       flags
);
    logic s1_valid_q, s1_valid_d, out_valid_q, out_valid_d, s1_adv, in_fire;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, exec_res;
    alu_op_e sel_q, sel_d;
    alu_flags_t flags_q, flags_d, exec_flags;

    alu_pipe_exec #(.WIDTH(WIDTH)) u_exec (
        .a(a_q), .b(b_q), .sel(sel_q), .result(exec_res), .flags(exec_flags)
    );

    always_comb begin
        s1_adv = s1_valid_q && (!out_valid_q || out_ready);
        in_ready = !rst && (!s1_valid_q || s1_adv);
        in_fire = in_valid && in_ready;
        s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
        a_d = in_fire ? a : a_q;
        b_d = in_fire ? b : b_q;
        sel_d = in_fire ? alu_op_e'(sel) : sel_q;
        out_valid_d = s1_adv || (out_valid_q && !out_ready);
        res_d = s1_adv ? exec_res : res_q;
        flags_d = s1_adv ? exec_flags : flags_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            sel_q <= OP_ADD;
            out_valid_q <= 1'b0;
            res_q <= '0;
            flags_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q <= a_d;
            b_q <= b_d;
            sel_q <= sel_d;
            out_valid_q <= out_valid_d;
            res_q <= res_d;
            flags_q <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out = res_q;
    assign flags = flags_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors, stall/reset sequences and random traffic against an arithmetic reference model.
module tb_alu_pipe;
    import alu_pipe_pkg::*;
    localparam int W = 16;

    logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, alu_out;
    logic [3:0] sel;
    logic [4:0] flags;

    int tests = 0, fails = 0, cyc = 0, stall_lo = 0, stall_hi = -1, out_cnt = 0;
    bit rand_ready = 0, saw_stall = 0, prev_stall = 0;
    logic [W+4:0] prev_out;
    logic [W+4:0] q[$];

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [4:0]   fl;
    } vec_t;
    vec_t vecs[17];

    alu_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .flags(flags)
    );

    always #5 clk = ~clk;

    function automatic logic [W+4:0] model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        longint m = (longint'(1) << W) - 1;
        longint half = longint'(1) << (W - 1);
        longint ua = longint'(av);
        longint ub = longint'(bv);
        longint sa = ua >= half ? ua - (m + 1) : ua;
        longint sb = ub >= half ? ub - (m + 1) : ub;
        int n = int'(ub % W);
        longint r = 0, s = 0;
        logic c = 0, v = 0, ill = 0;
        case (op)
            OP_ADD: begin r = ua + ub; c = r > m; s = sa + sb; v = s >= half || s < -half; end
            OP_SUB: begin r = ua - ub; c = ua < ub; s = sa - sb; v = s >= half || s < -half; end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_NOT: r = ~ua;
            OP_SHL: begin r = ua << n; c = n != 0 && ((ua >> (W - n)) & 1) != 0; end
            OP_SHR: begin r = ua >> n; c = n != 0 && ((ua >> (n - 1)) & 1) != 0; end
            OP_SAR: begin r = sa >>> n; c = n != 0 && ((ua >> (n - 1)) & 1) != 0; end
            OP_ROL: r = (ua << n) | (ua >> (W - n));
            OP_ROR: r = (ua >> n) | (ua << (W - n));
            OP_INC: begin r = ua + 1; c = ua == m; v = sa + 1 >= half; end
            OP_DEC: begin r = ua - 1; c = ua == 0; v = sa - 1 < -half; end
            OP_SLT: r = sa < sb ? 1 : 0;
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: begin r = ua * ub; c = (r >> W) != 0; end
`else
            OP_MUL: begin r = 0; ill = 1; end
`endif
            default: r = ub;
        endcase
        r = r & m;
        return {ill, v, r[W-1], r == 0, c, r[W-1:0]};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        out_ready = (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        bit acc = 0;
        in_valid = 1'b1;
        sel = op;
        a = av;
        b = bv;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) step();
        check("drain_empty", q.size(), 0);
    endtask

    task automatic apply_vec(input int i);
        in_valid = 1'b1;
        a = vecs[i].a;
        b = vecs[i].b;
        sel = vecs[i].op;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", i), in_ready, 1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d_latency1", i), out_valid, 0);
        step();
        @(negedge clk);
        check($sformatf("vec%0d_valid", i), out_valid, 1);
        check($sformatf("vec%0d_res", i), alu_out, vecs[i].res);
        check($sformatf("vec%0d_flags", i), flags, vecs[i].fl);
        step();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {flags, alu_out}, prev_out);
            end
            if (in_valid && in_ready) q.push_back(model(sel, a, b));
            if (out_valid && out_ready) begin
                out_cnt++;
                if (q.size() == 0) check("unexpected_result", q.size(), 1);
                else check("scoreboard", {flags, alu_out}, q.pop_front());
            end
            check("in_flight_le2", q.size() > 2, 0);
            if (!in_ready) saw_stall = 1;
            prev_stall = out_valid && !out_ready;
            prev_out = {flags, alu_out};
        end
    end

    initial begin
        int base;
        logic [W-1:0] edge_vals[5];
        vecs[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 5'b00011};
        vecs[1]  = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 5'b01000};
        vecs[2]  = '{OP_SAR,  16'h8001, 16'h0011, 16'hC000, 5'b00101};
        vecs[3]  = '{OP_SLT,  16'hFFFF, 16'h0001, 16'h0001, 5'b00000};
        vecs[4]  = '{OP_ROL,  16'h8001, 16'h0004, 16'h0018, 5'b00000};
`ifdef ALU_PIPE_MUL_EN
        vecs[5]  = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 5'b00011};
`else
        vecs[5]  = '{OP_MUL,  16'h0100, 16'h0100, 16'h0000, 5'b10010};
`endif
        vecs[6]  = '{OP_INC,  16'h7FFF, 16'h0000, 16'h8000, 5'b01100};
        vecs[7]  = '{OP_DEC,  16'h0000, 16'h0000, 16'hFFFF, 5'b00101};
        vecs[8]  = '{OP_SHL,  16'h0001, 16'h0000, 16'h0001, 5'b00000};
        vecs[9]  = '{OP_SHR,  16'h0003, 16'h0021, 16'h0001, 5'b00001};
        vecs[10] = '{OP_ROR,  16'h0001, 16'h0001, 16'h8000, 5'b00100};
        vecs[11] = '{OP_NOT,  16'h0000, 16'h1234, 16'hFFFF, 5'b00100};
        vecs[12] = '{OP_PASS, 16'h1234, 16'h0000, 16'h0000, 5'b00010};
        vecs[13] = '{OP_XOR,  16'h5555, 16'hAAAA, 16'hFFFF, 5'b00100};
        vecs[14] = '{OP_AND,  16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000};
        vecs[15] = '{OP_OR,   16'h0000, 16'h0000, 16'h0000, 5'b00010};
        vecs[16] = '{OP_SHL,  16'h8000, 16'h0001, 16'h0000, 5'b00011};
        edge_vals = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_alu_out", alu_out, 0);
        check("reset_flags", flags, 0);
        check("reset_in_ready", in_ready, 1);
        step();

        for (int i = 0; i < 17; i++) apply_vec(i);

        saw_stall = 0;
        base = out_cnt;
        stall_lo = cyc + 3;
        stall_hi = cyc + 5;
        for (int k = 0; k < 6; k++) send(4'((k * 3) % 16), 16'($urandom), 16'($urandom));
        drain();
        check("stall_result_count", out_cnt - base, 6);
        check("stall_in_ready_drop", saw_stall, 1);

        stall_lo = cyc + 1;
        stall_hi = cyc + 1000;
        send(OP_ADD, 16'h0001, 16'h0002);
        send(OP_SUB, 16'h0005, 16'h0003);
        @(negedge clk);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("in_reset_in_ready", in_ready, 0);
        step();
        rst = 1'b0;
        stall_hi = -1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_alu_out", alu_out, 0);
        check("post_rst_flags", flags, 0);
        check("post_rst_in_ready", in_ready, 1);
        base = out_cnt;
        repeat (5) step();
        check("post_rst_no_ghost", out_cnt - base, 0);

        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) step();
            send(4'($urandom_range(15)),
                 $urandom_range(2) == 0 ? edge_vals[$urandom_range(4)] : 16'($urandom),
                 $urandom_range(2) == 0 ? edge_vals[$urandom_range(4)] : 16'($urandom));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
